beat_sequencer: RTL
===================

BEAT_SEQUENCER -- requirements
Module: beat_sequencer

Interface
REQ-001 Parameter BEAT_DIV, default 5_000_000; clock cycles per beat at difficulty 0.
REQ-002 Parameter SAMPLE_DIV, default 2268; clock cycles per audio sample address step.
REQ-003 Parameter ADDR_W, default 16; width of audio_addr and beat_addr.
REQ-004 Parameter SONG_BEATS, default 1200; beats per song; song ends when beat_addr reaches it.
REQ-005 Parameter BEATS_PER_BAR, default 4; modulus of current_beat, range 2..16.
REQ-006 clk  input  1  single system clock; all logic on rising edge.
REQ-007 rst  input  1  synchronous, active-high reset.
REQ-008 game_start  input  1  start request, sampled in IDLE only.
REQ-009 game_stop  input  1  abort request, honoured in every state.
REQ-010 pause  input  1  level; high freezes a running song.
REQ-011 difficulty  input  4  tempo select, latched at start.
REQ-012 game_active  output  1  high in RUN and PAUSE.
REQ-013 beat_pulse / bar_pulse  output  1 each  one-cycle strobes.
REQ-014 current_beat  output  4  beat index within bar; song_done  output  1  one-cycle end strobe.
REQ-015 audio_addr / beat_addr  output  ADDR_W each  sample and beat-chart addresses; state  output  2  FSM state for debug.

Function
REQ-016 FSM states IDLE, RUN, PAUSE, DONE; IDLE->RUN on game_start; RUN->PAUSE on pause; PAUSE->RUN on !pause; RUN->DONE when beat_addr reaches SONG_BEATS; DONE->IDLE after one cycle.
REQ-017 game_stop moves any state to IDLE next cycle without song_done; stop wins over simultaneous start or pause.
REQ-018 IDLE->RUN clears beat counter, sample counter, beat_addr, audio_addr, current_beat; latches difficulty.
REQ-019 Beat period P = BEAT_DIV - difficulty*(BEAT_DIV/16), computed in 32 bits; P >= 1 for all legal parameters.
REQ-020 Beat counter runs 0..P-1 in RUN only; first RUN cycle counts 0; beat_pulse is high in the cycle after count P-1, i.e. P cycles after RUN entry, then every P RUN cycles.
REQ-021 beat_addr and current_beat update on the same edge that raises beat_pulse; current_beat wraps BEATS_PER_BAR-1 -> 0, and bar_pulse accompanies that wrapping beat_pulse.
REQ-022 audio_addr increments once per SAMPLE_DIV RUN cycles, wrapping modulo 2^ADDR_W.
REQ-023 PAUSE freezes all counters and addresses; resume continues from the frozen count, so a pause of K cycles delays the next beat by exactly K.
REQ-024 game_start while RUN/PAUSE/DONE ignored; difficulty changes after start ignored.
REQ-025 song_done high for exactly the DONE cycle; game_active low from that cycle; addresses hold until next start.

Reset
REQ-026 rst forces state IDLE and all outputs and counters to 0 at the next edge, overriding every input, including mid-song and mid-pause.

Configuration
REQ-027 Macro BEAT_SEQ_PAUSE_EN defined: pause behaves per REQ-016/023.
REQ-028 Macro undefined: pause input ignored, PAUSE state unreachable, RUN never freezes; all else identical.

Structure
REQ-029 Package beat_seq_pkg holds state encoding (IDLE=0, RUN=1, PAUSE=2, DONE=3) and default parameter constants.
REQ-030 Sub-module tick_divider (enable, clear, 32-bit period input, one-cycle tick output), instantiated for beat and sample timing.

Verification (BEAT_DIV=16, SAMPLE_DIV=4, SONG_BEATS=5, BEATS_PER_BAR=4)
REQ-031 Reset: assert rst mid-song -> next cycle state=0, all outputs 0.
REQ-032 Start, difficulty=0 -> beat_pulse at RUN entry+16, +32; audio_addr=4 at entry+16.
REQ-033 Start, difficulty=8 -> P=8; beat_pulse every 8 cycles; bar_pulse with 4th beat, current_beat 3->0.
REQ-034 Song end -> after 5th beat, song_done one cycle, game_active 0, state IDLE next cycle.
REQ-035 Pause 10 cycles at count 5 -> next beat_pulse 10 cycles later than unpaused; macro undefined -> no delay.
REQ-036 game_stop during PAUSE with game_start same cycle -> IDLE, no song_done; start next cycle -> RUN with zeroed addresses.

Source files
------------

// File: rtl/beat_seq_pkg.sv
// beat_seq_pkg: state encoding, default parameters and beat-period helper for beat_sequencer
package beat_seq_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2, DONE = 2'd3} state_t;
  localparam int unsigned BEAT_DIV_DEF = 5_000_000;
  localparam int unsigned SAMPLE_DIV_DEF = 2268;
  localparam int unsigned ADDR_W_DEF = 16;
  localparam int unsigned SONG_BEATS_DEF = 1200;
  localparam int unsigned BEATS_PER_BAR_DEF = 4;
  function automatic logic [31:0] beat_period(input logic [31:0] div, input logic [3:0] d);
    return div - 32'(d) * (div / 32'd16);
  endfunction
endpackage

// File: rtl/beat_sequencer_tick_divider.sv
// tick_divider: counts enabled cycles 0..period-1, tick marks the cycle that wraps the count
module tick_divider (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        clear,
  input  logic [31:0] period,
  output logic        tick
);
  logic [31:0] cnt;
  assign tick = en && !clear && cnt == period - 32'd1;
  always_ff @(posedge clk)
    if (rst || clear) cnt <= '0;
    else if (en) cnt <= tick ? '0 : cnt + 32'd1;
endmodule

// File: rtl/beat_sequencer.sv
// beat_sequencer: song tempo FSM with beat/bar strobes and audio/chart addresses; pause support under BEAT_SEQ_PAUSE_EN
module beat_sequencer
  import beat_seq_pkg::*;
#(
  parameter int unsigned BEAT_DIV      = BEAT_DIV_DEF,
  parameter int unsigned SAMPLE_DIV    = SAMPLE_DIV_DEF,
  parameter int unsigned ADDR_W        = ADDR_W_DEF,
  parameter int unsigned SONG_BEATS    = SONG_BEATS_DEF,
  parameter int unsigned BEATS_PER_BAR = BEATS_PER_BAR_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              game_start,
  input  logic              game_stop,
  input  logic              pause,
  input  logic [3:0]        difficulty,
  output logic              game_active,
  output logic              beat_pulse,
  output logic              bar_pulse,
  output logic [3:0]        current_beat,
  output logic              song_done,
  output logic [ADDR_W-1:0] audio_addr,
  output logic [ADDR_W-1:0] beat_addr,
  output logic [1:0]        state
);
  state_t st, st_nxt;
  logic [3:0] diff_q;
  logic pause_in, song_end, start_go, run_en, beat_tick, sample_tick;
`ifdef BEAT_SEQ_PAUSE_EN
  assign pause_in = pause;
`else
  assign pause_in = pause & 1'b0;
`endif
  assign song_end = beat_addr == ADDR_W'(SONG_BEATS);
  assign start_go = st == IDLE && game_start && !game_stop;
  // the last RUN cycle (song already complete) counts nothing so addresses stay at the song end
  assign run_en = st == RUN && !song_end;
  assign song_done = st == DONE;
  assign game_active = st == RUN || st == PAUSE;
  assign state = st;
  tick_divider u_beat (
    .clk(clk), .rst(rst), .en(run_en), .clear(start_go),
    .period(beat_period(32'(BEAT_DIV), diff_q)), .tick(beat_tick)
  );
  tick_divider u_sample (
    .clk(clk), .rst(rst), .en(run_en), .clear(start_go),
    .period(32'(SAMPLE_DIV)), .tick(sample_tick)
  );
  always_comb begin
    st_nxt = st;
    case (st)
      IDLE:  st_nxt = game_start ? RUN : IDLE;
      RUN:   st_nxt = song_end ? DONE : pause_in ? PAUSE : RUN;
      PAUSE: st_nxt = pause_in ? PAUSE : RUN;
      DONE:  st_nxt = IDLE;
    endcase
    if (game_stop) st_nxt = IDLE;
  end
  always_ff @(posedge clk)
    if (rst) begin
      st <= IDLE;
      diff_q <= '0;
      beat_addr <= '0;
      audio_addr <= '0;
      current_beat <= '0;
      beat_pulse <= 1'b0;
      bar_pulse <= 1'b0;
    end else begin
      st <= st_nxt;
      beat_pulse <= beat_tick;
      bar_pulse <= beat_tick && current_beat == 4'(BEATS_PER_BAR - 1);
      if (start_go) begin
        diff_q <= difficulty;
        beat_addr <= '0;
        audio_addr <= '0;
        current_beat <= '0;
      end else begin
        if (beat_tick) begin
          beat_addr <= beat_addr + ADDR_W'(1);
          current_beat <= current_beat == 4'(BEATS_PER_BAR - 1) ? 4'd0 : current_beat + 4'd1;
        end
        if (sample_tick) audio_addr <= audio_addr + ADDR_W'(1);
      end
    end
endmodule
